// File: rtl/control_pkg.sv
// Shared state encoding and dispatch-class helpers for the multicycle control sequencer.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package control_pkg;

  // State is an open 7-bit code because dispatch loads the encoder's value directly.
  typedef logic [6:0] state_t;

  localparam state_t ST_RESET     = 7'd0;
  localparam state_t ST_FETCH0    = 7'd1;
  localparam state_t ST_FETCH1    = 7'd2;
  localparam state_t ST_FETCH2    = 7'd3;
  localparam state_t ST_DECODE    = 7'd4;
  localparam state_t ST_ILLEGAL   = 7'd5;
  localparam state_t ST_ADDU      = 7'd6;
  localparam state_t ST_STORE0    = 7'd7;
  localparam state_t ST_STORE1    = 7'd8;
  localparam state_t ST_STORE2    = 7'd9;
  localparam state_t ST_BEQ       = 7'd11;
  localparam state_t ST_BRANCH    = 7'd12;
  localparam state_t ST_LOAD0     = 7'd13;
  localparam state_t ST_LOAD1     = 7'd14;
  localparam state_t ST_LOAD2     = 7'd15;
  localparam state_t ST_LOAD3     = 7'd16;
  localparam state_t ST_ALU_FIRST = 7'd17;
  localparam state_t ST_ALU_LAST  = 7'd28;

  function automatic logic is_alu(state_t s);
    return (s == ST_ADDU) || ((s >= ST_ALU_FIRST) && (s <= ST_ALU_LAST));
  endfunction

  function automatic logic is_dispatch_valid(state_t sel);
    return is_alu(sel) || (sel == ST_STORE0) || (sel == ST_BEQ) || (sel == ST_LOAD0);
  endfunction

  function automatic logic is_wait_state(state_t s);
    return (s == ST_FETCH1) || (s == ST_STORE2) || (s == ST_LOAD2);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Encoder/memory/ALU-facing signals of the control sequencer, with sequencer (slave) and environment (master) views.
// Latency: wires only.
// Backpressure: Hold freezes the sequencer; MOC is a level-sensitive memory completion.
interface control_sequencer_if;
  import control_pkg::*;

  state_t State_Sel;
  logic   MOC;
  logic   Cond;
  logic   Hold;
  state_t State;
  logic   Retire;
  logic   Illegal_Op;
  logic   Bus_Error;

  modport master (
    output State_Sel, MOC, Cond, Hold,
    input  State, Retire, Illegal_Op, Bus_Error
  );

  modport slave (
    input  State_Sel, MOC, Cond, Hold,
    output State, Retire, Illegal_Op, Bus_Error
  );

endinterface

// File: rtl/moc_watchdog.sv
// Counts consecutive stalled cycles in a memory-wait state and strobes timeout; keeps the sticky bus error.
// Latency: timeout is combinational on the MOC_TIMEOUT-th stalled cycle; bus_error registers at that edge.
// Backpressure: hold freezes the count and the flag.
module moc_watchdog
  import control_pkg::*;
#(
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  state_t state,
  input  logic   moc,
  input  logic   hold,
  output logic   timeout,
  output logic   bus_error
);

  localparam int unsigned CW = $clog2(MOC_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MOC_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic          stalled;

  assign stalled = is_wait_state(state) && !moc && !hold;
  assign timeout = stalled && (count_q == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q   <= '0;
      bus_error <= 1'b0;
    end else if (!hold) begin
      // Leaving the wait state (MOC seen, or timeout) restarts the count.
      if (!stalled || timeout) count_q <= '0;
      else                     count_q <= count_q + 1'b1;
      if (timeout) bus_error <= 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle MIPS control-state sequencer: fetch/decode, per-class execute, memory waits; SEQ_MOC_TIMEOUT_EN adds a wait watchdog.
// Latency: State_Sel sampled in decode appears on State at the next edge; Retire decodes the current cycle.
// Backpressure: Hold freezes State and counters; wait states stall until MOC.
module control_sequencer
#(
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input logic                 Clk,
  input logic                 Reset_n,
  control_sequencer_if.slave  bus
);
  import control_pkg::*;

  state_t state_q, state_d;
  logic   retire;
  logic   timeout;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (!bus.Hold) begin
      case (state_q)
        ST_RESET:   state_d = ST_FETCH0;
        ST_FETCH0:  state_d = ST_FETCH1;
        ST_FETCH1:  if (bus.MOC) state_d = ST_FETCH2;
        ST_FETCH2:  state_d = ST_DECODE;
        ST_DECODE:  state_d = is_dispatch_valid(bus.State_Sel) ? bus.State_Sel : ST_ILLEGAL;
        ST_ILLEGAL: state_d = ST_FETCH0;
        ST_STORE0:  state_d = ST_STORE1;
        ST_STORE1:  state_d = ST_STORE2;
        ST_STORE2: begin
          if (bus.MOC) begin
            state_d = ST_FETCH0;
            retire  = 1'b1;
          end
        end
        ST_BEQ: begin
          state_d = bus.Cond ? ST_BRANCH : ST_FETCH0;
          retire  = !bus.Cond;
        end
        ST_BRANCH: begin
          state_d = ST_FETCH0;
          retire  = 1'b1;
        end
        ST_LOAD0:   state_d = ST_LOAD1;
        ST_LOAD1:   state_d = ST_LOAD2;
        ST_LOAD2:   if (bus.MOC) state_d = ST_LOAD3;
        ST_LOAD3: begin
          state_d = ST_FETCH0;
          retire  = 1'b1;
        end
        // ALU classes retire here; unused codes fall back to fetch without retiring.
        default: begin
          state_d = ST_FETCH0;
          retire  = is_alu(state_q);
        end
      endcase
      if (timeout) begin
        state_d = ST_ILLEGAL;
        retire  = 1'b0;
      end
    end
  end

`ifdef SEQ_MOC_TIMEOUT_EN
  moc_watchdog #(
    .MOC_TIMEOUT (MOC_TIMEOUT)
  ) u_moc_watchdog (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .state     (state_q),
    .moc       (bus.MOC),
    .hold      (bus.Hold),
    .timeout   (timeout),
    .bus_error (bus.Bus_Error)
  );
`else
  assign timeout       = 1'b0;
  assign bus.Bus_Error = 1'b0;
`endif

  assign bus.State      = state_q;
  assign bus.Retire     = retire;
  assign bus.Illegal_Op = (state_q == ST_ILLEGAL);

endmodule
